// File: rtl/sram_port_arb_pkg.sv
// sram_arb_pkg: shared helpers for the SRAM port arbiter.
//   sw_of   : byte-strobe width for a given data width
//   rr_pick : round-robin one-hot grant from a request vector and a pointer
package sram_arb_pkg;
   localparam int MAXN = 16;
   function automatic int sw_of(input int dw);
      return (dw + 7) / 8;
   endfunction
   // Scan n requesters starting at ptr (wrapping); first hit wins.
   function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] req, input int ptr, input int n);
      logic [MAXN-1:0] g;
      int idx;
      g = '0;
      for (int k = 0; k < MAXN; k++) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (req[idx] && g == '0) g[idx] = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/sram_port_arb_if.sv
// sram_port_arb_if: requester-side request/response bus, flattened per requester.
//   master : requesters (drive req_*, resp_ready)
//   slave  : arbiter (drives req_ready, resp_valid, resp_data)
interface sram_port_arb_if #(
   parameter int DW   = 32,
   parameter int AW   = 14,
   parameter int NREQ = 2
);
   import sram_arb_pkg::*;
   localparam int SW = sw_of(DW);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_wen;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ*SW-1:0]   req_wstrb;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready;
   logic [NREQ*DW-1:0]   resp_data;
   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_data
   );
   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/sram_port_arb_rr_arb.sv
// rr_arb: N-way round-robin arbiter with its own pointer.
//   CLK, RST : clock, synchronous active-high reset (pointer -> 0, grant forced low)
//   req      : request vector
//   gnt      : one-hot grant, combinational from req; pointer moves to grant+1
module rr_arb
   import sram_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = $clog2(N);
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [MAXN-1:0] pick;
   logic            unused_pick;
   assign pick        = rr_pick(MAXN'(req), int'(ptr), N);
   assign unused_pick = ^pick;
   assign gnt         = RST ? '0 : pick[N-1:0];
   always_comb begin
      ptr_nxt = ptr;
      for (int k = 0; k < N; k++)
         if (gnt[k]) ptr_nxt = (k == N - 1) ? '0 : PW'(k + 1);
   end
   always_ff @(posedge CLK)
      ptr <= RST ? '0 : ptr_nxt;
endmodule

// File: rtl/sram_port_arb.sv
// sram_port_arb: shares one simple-dual-port SRAM among NREQ requesters.
//   CLK, RST      : clock, synchronous active-high reset
//   bus (slave)   : per-requester valid/ready request and response channels
//   sram_*_w      : SRAM write port (en, addr, data, byte strobes)
//   sram_*_r      : SRAM read port (en, addr); sram_data_r valid the cycle after en
module sram_port_arb
   import sram_arb_pkg::*;
#(
   parameter  int DW   = 32,
   parameter  int AW   = 14,
   parameter  int NREQ = 2,
   localparam int SW   = sw_of(DW)
) (
   input  logic          CLK,
   input  logic          RST,
   sram_port_arb_if.slave bus,
   output logic          sram_en_w,
   output logic [AW-1:0] sram_addr_w,
   output logic [DW-1:0] sram_data_w,
   output logic [SW-1:0] sram_wstrb,
   output logic          sram_en_r,
   output logic [AW-1:0] sram_addr_r,
   input  logic [DW-1:0] sram_data_r
);
   logic [NREQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt, rd_ok, inflight, hold_valid;
   assign wr_req = bus.req_valid & bus.req_wen;
   // A requester may only issue a read if its previous response cannot be left stranded.
   assign rd_ok  = ~hold_valid & ~(inflight & ~bus.resp_ready);
   assign rd_req = bus.req_valid & ~bus.req_wen & rd_ok;
   rr_arb #(.N(NREQ)) u_wr_arb (.CLK(CLK), .RST(RST), .req(wr_req), .gnt(wr_gnt));
   rr_arb #(.N(NREQ)) u_rd_arb (.CLK(CLK), .RST(RST), .req(rd_req), .gnt(rd_gnt));
   assign bus.req_ready = wr_gnt | rd_gnt;
   always_comb begin
      sram_en_w   = |wr_gnt;
      sram_addr_w = '0;
      sram_data_w = '0;
      sram_wstrb  = '0;
      sram_en_r   = |rd_gnt;
      sram_addr_r = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (wr_gnt[k]) begin
            sram_addr_w = bus.req_addr[k*AW +: AW];
            sram_data_w = bus.req_wdata[k*DW +: DW];
            sram_wstrb  = bus.req_wstrb[k*SW +: SW];
         end
         if (rd_gnt[k]) sram_addr_r = bus.req_addr[k*AW +: AW];
      end
   end
   for (genvar i = 0; i < NREQ; i++) begin : g_resp
      logic          infl, hv;
      logic [DW-1:0] hd;
      // Read data is live on sram_data_r for one cycle only; park it if not consumed.
      always_ff @(posedge CLK) begin
         if (RST) begin
            infl <= 1'b0;
            hv   <= 1'b0;
            hd   <= '0;
         end else begin
            infl <= rd_gnt[i];
            if (infl & ~bus.resp_ready[i]) begin
               hv <= 1'b1;
               hd <= sram_data_r;
            end else if (hv & bus.resp_ready[i]) begin
               hv <= 1'b0;
            end
         end
      end
      assign inflight[i]              = infl;
      assign hold_valid[i]            = hv;
      assign bus.resp_valid[i]        = ~RST & (hv | infl);
      assign bus.resp_data[i*DW +: DW] = hv ? hd : infl ? sram_data_r : '0;
   end
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: directed bench for sram_port_arb with a behavioural SRAM model.
module tb_sram_port_arb;
   localparam int DW = 32, AW = 14, NREQ = 2, SW = 4;
   logic          CLK = 1'b0, RST = 1'b1;
   logic          sram_en_w, sram_en_r;
   logic [AW-1:0] sram_addr_w, sram_addr_r;
   logic [DW-1:0] sram_data_w, sram_data_r;
   logic [SW-1:0] sram_wstrb;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            passed = 0, total = 0;
   sram_port_arb_if #(.DW(DW), .AW(AW), .NREQ(NREQ)) bus ();
   sram_port_arb #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
      .CLK(CLK), .RST(RST), .bus(bus.slave),
      .sram_en_w(sram_en_w), .sram_addr_w(sram_addr_w), .sram_data_w(sram_data_w),
      .sram_wstrb(sram_wstrb), .sram_en_r(sram_en_r), .sram_addr_r(sram_addr_r),
      .sram_data_r(sram_data_r)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) begin
      if (sram_en_r) sram_data_r <= mem[sram_addr_r];
      if (sram_en_w)
         for (int b = 0; b < SW; b++)
            if (sram_wstrb[b]) mem[sram_addr_w][b*8 +: 8] <= sram_data_w[b*8 +: 8];
   end
   task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      bus.req_valid[i]          = v;
      bus.req_wen[i]            = w;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_wdata[i*DW +: DW] = d;
      bus.req_wstrb[i*SW +: SW] = s;
   endtask
   task automatic idle();
      bus.req_valid  = '0;
      bus.req_wen    = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.resp_ready = '1;
   endtask
   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      idle();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask
   task automatic test_reset();
      @(negedge CLK);
      RST = 1'b1;
      idle();
      set_req(0, 1, 0, 14'h10, 0, 0);
      set_req(1, 1, 0, 14'h20, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      #1;
      total++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready got %b exp 00", bus.req_ready); else passed++;
      total++; if (bus.resp_valid !== 2'b00) $display("FAIL rst_resp_valid got %b exp 00", bus.resp_valid); else passed++;
      total++; if ({sram_en_w, sram_en_r} !== 2'b00) $display("FAIL rst_sram_en got %b exp 00", {sram_en_w, sram_en_r}); else passed++;
      total++; if ({sram_addr_w, sram_addr_r} !== '0) $display("FAIL rst_sram_addr got %h exp 0", {sram_addr_w, sram_addr_r}); else passed++;
      RST = 1'b0;
      #1;
      total++; if (bus.req_ready !== 2'b01) $display("FAIL rst_first_grant got %b exp 01", bus.req_ready); else passed++;
      total++; if (sram_addr_r !== 14'h10) $display("FAIL rst_first_addr got %h exp 10", sram_addr_r); else passed++;
      @(negedge CLK);
      idle();
      #1;
      total++; if (bus.resp_data[DW-1:0] !== 32'hA0A0_0010) $display("FAIL rst_first_data got %h exp a0a00010", bus.resp_data[DW-1:0]); else passed++;
   endtask
   task automatic test_contention();
      logic [1:0]    eg, ev;
      int            j;
      logic [DW-1:0] ed;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         if (c < 4) begin
            set_req(0, 1, 0, 14'h10, 0, 0);
            set_req(1, 1, 0, 14'h20, 0, 0);
         end else idle();
         #1;
         if (c < 4) begin
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (bus.req_ready !== eg) $display("FAIL cont_grant c%0d got %b exp %b", c, bus.req_ready, eg); else passed++;
         end
         if (c > 0) begin
            j  = (c % 2 == 1) ? 0 : 1;
            ev = (j == 0) ? 2'b01 : 2'b10;
            ed = (j == 0) ? 32'hA0A0_0010 : 32'hB0B0_0020;
            total++; if (bus.resp_valid !== ev) $display("FAIL cont_valid c%0d got %b exp %b", c, bus.resp_valid, ev); else passed++;
            total++; if (bus.resp_data[j*DW +: DW] !== ed) $display("FAIL cont_data c%0d got %h exp %h", c, bus.resp_data[j*DW +: DW], ed); else passed++;
         end
         @(negedge CLK);
      end
   endtask
   task automatic test_backpressure();
      do_reset();
      bus.resp_ready[1] = 1'b0;
      set_req(1, 1, 0, 14'h5, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b10) $display("FAIL bp_issue got %b exp 10", bus.req_ready); else passed++;
      @(negedge CLK);
      set_req(0, 1, 0, 14'h6, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b01) $display("FAIL bp_block1 got %b exp 01", bus.req_ready); else passed++;
      total++; if (bus.resp_valid !== 2'b10) $display("FAIL bp_valid1 got %b exp 10", bus.resp_valid); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'hDEADBEEF) $display("FAIL bp_data1 got %h exp deadbeef", bus.resp_data[2*DW-1:DW]); else passed++;
      @(negedge CLK);
      set_req(0, 0, 0, 0, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b00) $display("FAIL bp_block2 got %b exp 00", bus.req_ready); else passed++;
      total++; if (bus.resp_valid !== 2'b11) $display("FAIL bp_valid2 got %b exp 11", bus.resp_valid); else passed++;
      total++; if (bus.resp_data[DW-1:0] !== 32'h1234_5678) $display("FAIL bp_data0 got %h exp 12345678", bus.resp_data[DW-1:0]); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'hDEADBEEF) $display("FAIL bp_data2 got %h exp deadbeef", bus.resp_data[2*DW-1:DW]); else passed++;
      @(negedge CLK);
      #1;
      total++; if (bus.req_ready !== 2'b00) $display("FAIL bp_block3 got %b exp 00", bus.req_ready); else passed++;
      total++; if (bus.resp_valid !== 2'b10) $display("FAIL bp_valid3 got %b exp 10", bus.resp_valid); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'hDEADBEEF) $display("FAIL bp_data3 got %h exp deadbeef", bus.resp_data[2*DW-1:DW]); else passed++;
      @(negedge CLK);
      bus.resp_ready[1] = 1'b1;
      set_req(1, 0, 0, 0, 0, 0);
      #1;
      total++; if (bus.resp_valid[1] !== 1'b1) $display("FAIL bp_release_valid got %b exp 1", bus.resp_valid[1]); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'hDEADBEEF) $display("FAIL bp_release_data got %h exp deadbeef", bus.resp_data[2*DW-1:DW]); else passed++;
      @(negedge CLK);
      #1;
      total++; if (bus.resp_valid !== 2'b00) $display("FAIL bp_drained got %b exp 00", bus.resp_valid); else passed++;
   endtask
   task automatic test_collision();
      do_reset();
      set_req(0, 1, 1, 14'h7, 32'hAAAA_5555, 4'hF);
      set_req(1, 1, 0, 14'h7, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b11) $display("FAIL col_grant got %b exp 11", bus.req_ready); else passed++;
      total++; if ({sram_en_w, sram_en_r} !== 2'b11) $display("FAIL col_en got %b exp 11", {sram_en_w, sram_en_r}); else passed++;
      total++; if (sram_addr_w !== 14'h7) $display("FAIL col_addr_w got %h exp 7", sram_addr_w); else passed++;
      total++; if (sram_data_w !== 32'hAAAA_5555) $display("FAIL col_data_w got %h exp aaaa5555", sram_data_w); else passed++;
      @(negedge CLK);
      set_req(0, 0, 0, 0, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b10) $display("FAIL col_reread got %b exp 10", bus.req_ready); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'h0BAD_F00D) $display("FAIL col_old got %h exp 0badf00d", bus.resp_data[2*DW-1:DW]); else passed++;
      @(negedge CLK);
      idle();
      #1;
      total++; if (bus.resp_valid !== 2'b10) $display("FAIL col_new_valid got %b exp 10", bus.resp_valid); else passed++;
      total++; if (bus.resp_data[2*DW-1:DW] !== 32'hAAAA_5555) $display("FAIL col_new got %h exp aaaa5555", bus.resp_data[2*DW-1:DW]); else passed++;
   endtask
   task automatic test_strobe();
      do_reset();
      set_req(0, 1, 1, 14'h9, 32'h1122_3344, 4'b0101);
      #1;
      total++; if (sram_wstrb !== 4'b0101) $display("FAIL strb_wstrb got %b exp 0101", sram_wstrb); else passed++;
      @(negedge CLK);
      set_req(0, 1, 0, 14'h9, 0, 0);
      @(negedge CLK);
      idle();
      #1;
      total++; if (bus.resp_data[DW-1:0] !== 32'hFF22_FF44) $display("FAIL strb_readback got %h exp ff22ff44", bus.resp_data[DW-1:0]); else passed++;
   endtask
   task automatic test_reset_midflight();
      do_reset();
      set_req(0, 1, 0, 14'h10, 0, 0);
      #1;
      total++; if (bus.req_ready !== 2'b01) $display("FAIL mid_grant got %b exp 01", bus.req_ready); else passed++;
      @(negedge CLK);
      RST = 1'b1;
      idle();
      #1;
      total++; if (bus.resp_valid !== 2'b00) $display("FAIL mid_valid_a got %b exp 00", bus.resp_valid); else passed++;
      @(negedge CLK);
      #1;
      total++; if (bus.resp_valid !== 2'b00) $display("FAIL mid_valid_b got %b exp 00", bus.resp_valid); else passed++;
      @(negedge CLK);
      RST = 1'b0;
      set_req(0, 1, 0, 14'h10, 0, 0);
      set_req(1, 1, 0, 14'h20, 0, 0);
      #1;
      total++; if (bus.resp_valid !== 2'b00) $display("FAIL mid_valid_c got %b exp 00", bus.resp_valid); else passed++;
      total++; if (bus.req_ready !== 2'b01) $display("FAIL mid_ptr got %b exp 01", bus.req_ready); else passed++;
      @(negedge CLK);
      idle();
      #1;
      total++; if (bus.resp_valid !== 2'b01) $display("FAIL mid_resume_valid got %b exp 01", bus.resp_valid); else passed++;
      total++; if (bus.resp_data[DW-1:0] !== 32'hA0A0_0010) $display("FAIL mid_resume_data got %h exp a0a00010", bus.resp_data[DW-1:0]); else passed++;
   endtask
   initial begin
      idle();
      mem[14'h05] = 32'hDEAD_BEEF;
      mem[14'h06] = 32'h1234_5678;
      mem[14'h07] = 32'h0BAD_F00D;
      mem[14'h09] = 32'hFFFF_FFFF;
      mem[14'h10] = 32'hA0A0_0010;
      mem[14'h20] = 32'hB0B0_0020;
      test_reset();
      test_contention();
      test_backpressure();
      test_collision();
      test_strobe();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sram_port_arb.md
# sram_port_arb

Two-channel round-robin arbiter that shares one simple-dual-port `gen_sram` instance (independent write and read ports, 1-cycle registered read) among `NREQ` requesters. Each requester issues reads or writes over a valid/ready request channel and receives read data on a valid/ready response channel. One write and one read are granted per cycle, from different or the same requester. Sits between cache/TCM clients and the SRAM macro wrapper in the core testbench and memory subsystem.

## Interface
- `DW`, 32, data width; `SW = (DW+7)/8` strobe bits
- `AW`, 14, word address width
- `NREQ`, 2, number of requesters (≥2)
- `CLK` in 1: single clock, rising edge
- `RST` in 1: synchronous, active-high reset
- `req_valid` in NREQ: request present, one bit per requester
- `req_ready` out NREQ: request accepted this cycle
- `req_wen` in NREQ: 1 = write, 0 = read
- `req_addr` in NREQ*AW: flattened; requester i at `[i*AW+:AW]`
- `req_wdata` in NREQ*DW: flattened write data
- `req_wstrb` in NREQ*SW: flattened byte strobes
- `resp_valid` out NREQ: read data valid
- `resp_ready` in NREQ: response consumed
- `resp_data` out NREQ*DW: flattened read data
- `sram_en_w` out 1, `sram_addr_w` out AW, `sram_data_w` out DW, `sram_wstrb` out SW: SRAM write port
- `sram_en_r` out 1, `sram_addr_r` out AW: SRAM read port
- `sram_data_r` in DW: SRAM read data, valid the cycle after `sram_en_r`

## Operation
- Write and read channels are arbitrated independently, each with its own round-robin pointer; reset pointer = 0 (requester 0 highest priority).
- Write candidates: `req_valid[i] & req_wen[i]`. Grant the first candidate at or after the pointer (wrapping). The grant drives `sram_en_w`/addr/data/strb combinationally the same cycle; `req_ready[i]` = grant. The pointer moves to grant+1 mod NREQ; with no grant it holds.
- Read candidates: `req_valid[i] & ~req_wen[i] & rd_ok[i]`, same round-robin rule. The grant drives `sram_en_r`/`sram_addr_r`.
- Per-requester response state: `inflight[i]` (read issued last cycle) and a 1-entry hold register `hold_valid[i]`/`hold_data[i]`.
- `rd_ok[i] = ~hold_valid[i] & ~(inflight[i] & ~resp_ready[i])`. At most one unconsumed response per requester. There is a combinational path from `resp_ready` to `req_ready`.
- Response mux: if `hold_valid[i]`, present `hold_data[i]`. Otherwise, if `inflight[i]`, present `sram_data_r` directly. `resp_valid[i] = hold_valid[i] | inflight[i]`.
- If `inflight[i] & ~resp_ready[i]`: capture `sram_data_r` into hold and set `hold_valid`. If `hold_valid & resp_ready`: clear hold.
- Same-cycle write and read to one address: the read returns the pre-write data (SRAM read-old). No forwarding.
- `sram_en_r` is low whenever no read is granted, so `sram_data_r` is never relied on after its issue cycle.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `sram_en_w=0`, `sram_en_r=0`, all `hold_valid`/`inflight`=0, both pointers=0. Address/data outputs are don't-care when their enable is low; drive them 0.
- Write latency: accepted and written at the edge ending cycle T.
- Read latency: accepted at T; `resp_valid` and data at T+1. Under backpressure, data stays stable from T+1 until `resp_ready`.
- Throughput: one read per requester per cycle while `resp_ready` is held high; aggregate one read and one write per cycle.
- Reset asserted mid-operation: in-flight reads and held responses are discarded with no response; pointers return to 0. Writes already granted have completed.
- A request held valid with ready low keeps its fields stable (requester obligation). Starvation bound: NREQ-1 cycles per channel.

## Structure
- Shared package `sram_arb_pkg`: `SW` width function and round-robin grant helper (`rr_pick`: request vector + pointer → one-hot grant).
- One sub-module `rr_arb` (parameter `N`; inputs `CLK`, `RST`, `req`; output one-hot `gnt`; holds its pointer), instantiated twice for the write and read channels.
- Response hold logic is generated per requester inside the top module.

## Test plan
- Reset: after `RST` for 2 cycles, all outputs are at reset values; the first grant with both requesting goes to requester 0.
- Contention: both requesters issue back-to-back reads of 0x10 and 0x20 for 4 cycles → grants alternate 0,1,0,1; each `resp_data` matches preloaded memory one cycle after its grant.
- Backpressure: requester 1 reads 0x5 (preload 0xDEADBEEF) with `resp_ready[1]=0` for 3 cycles → `resp_valid[1]` stays high with stable data; `req_ready[1]` stays low for reads; data released on `resp_ready`.
- Read/write collision: requester 0 writes 0xAAAA5555 to 0x7 while requester 1 reads 0x7 in the same cycle → read returns the old value; a read of 0x7 on the next cycle returns 0xAAAA5555.
- Partial strobe: write 0x11223344 with `wstrb=4'b0101` over 0xFFFFFFFF → readback 0xFF22FF44.
- Reset mid-flight: assert `RST` in the cycle after a read grant → no `resp_valid` follows; normal operation resumes after reset.
